// File: rtl/shift_sequencer.sv
// Multi-cycle shifter/rotator: one 1-bit step per clock over a byte or word,
// producing result plus CY/V/P/S/Z flags with per-flag write enables.
module shift_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        size,
    input  logic [15:0] operand,
    input  logic [7:0]  count,
    input  logic        cy_in,
    output logic        ready,
    output logic        done,
    output logic [15:0] result,
    output logic [5:0]  flags,
    output logic [5:0]  flags_we
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic [4:0]  n_in;
    logic [2:0]  op_r;
    logic        size_r;
    logic [15:0] val;
    logic        cy;
    logic [4:0]  n;
    logic        orig_msb;
    logic        msb_b;
    logic        ins;
    logic [15:0] step_val;
    logic        step_cy;
    logic        res_msb;
    logic        res_msb1;
    logic        v_flag;
    logic        z_flag;
    logic [5:0]  fin_flags;
    logic [5:0]  fin_we;
    logic        unused_count_bits;

    assign n_in              = count[4:0];
    assign unused_count_bits = ^count[7:5];
    assign ready             = (state == IDLE);
    assign done              = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept    = 1'b1;
                state_nxt = (n_in != 5'd0) ? SHIFT : DONE;
            end
            SHIFT:   if (n == 5'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One step: even opcodes move left, odd opcodes move right.
    always_comb begin
        msb_b = size_r ? val[15] : val[7];
        case (op_r)
            3'd0, 3'd7: ins = msb_b;
            3'd1:       ins = val[0];
            3'd2, 3'd3: ins = cy;
            default:    ins = 1'b0;
        endcase
        if (!op_r[0]) begin
            step_cy  = msb_b;
            step_val = size_r ? {val[14:0], ins} : {val[15:8], val[6:0], ins};
        end else begin
            step_cy  = val[0];
            step_val = size_r ? {ins, val[15:1]} : {val[15:8], ins, val[7:1]};
        end
    end

    // Flags from the final step, only used when n reaches zero.
    always_comb begin
        res_msb  = size_r ? step_val[15] : step_val[7];
        res_msb1 = size_r ? step_val[14] : step_val[6];
        case (op_r)
            3'd1, 3'd3: v_flag = res_msb ^ res_msb1;
            3'd5:       v_flag = orig_msb;
            3'd7:       v_flag = 1'b0;
            default:    v_flag = res_msb ^ step_cy;
        endcase
        z_flag    = size_r ? (step_val == 16'h0000) : (step_val[7:0] == 8'h00);
        fin_flags = {z_flag, res_msb, ~^step_val[7:0], v_flag, step_cy, 1'b0};
        fin_we    = op_r[2] ? 6'b111110 : 6'b000110;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r     <= 3'd0;
            size_r   <= 1'b0;
            val      <= 16'h0000;
            cy       <= 1'b0;
            n        <= 5'd0;
            orig_msb <= 1'b0;
            result   <= 16'h0000;
            flags    <= 6'd0;
            flags_we <= 6'd0;
        end else if (accept) begin
            op_r     <= op;
            size_r   <= size;
            val      <= operand;
            cy       <= cy_in;
            n        <= n_in;
            orig_msb <= size ? operand[15] : operand[7];
            if (n_in == 5'd0) begin
                result   <= operand;
                flags    <= 6'd0;
                flags_we <= 6'd0;
            end
        end else if (state == SHIFT) begin
            val <= step_val;
            cy  <= step_cy;
            n   <= n - 5'd1;
            if (n == 5'd1) begin
                result   <= step_val;
                flags    <= fin_flags;
                flags_we <= fin_we;
            end
        end
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The module SHALL have the port clk, input, 1 bit: rising-edge clock.
REQ-003 The module SHALL have the port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have the port start, input, 1 bit: request, sampled only while ready=1.
REQ-005 The module SHALL have the port op, input, 3 bits: 0 ROL, 1 ROR, 2 ROLC, 3 RORC, 4 SHL, 5 SHR, 7 SHRA, with 6 treated as SHL.
REQ-006 The module SHALL have the port size, input, 1 bit: 0 byte (bits 7:0), 1 word.
REQ-007 The module SHALL have the port operand, input, 16 bits: value to shift.
REQ-008 The module SHALL have the port count, input, 8 bits: shift count.
REQ-009 The module SHALL have the port cy_in, input, 1 bit: carry-in for ROLC/RORC.
REQ-010 The module SHALL have the port ready, output, 1 bit: idle, able to accept start.
REQ-011 The module SHALL have the port done, output, 1 bit: one-cycle result-valid pulse.
REQ-012 The module SHALL have the port result, output, 16 bits: shifted value.
REQ-013 The module SHALL have the port flags, output, 6 bits: bit 0 AC, 1 CY, 2 V, 3 P, 4 S, 5 Z.
REQ-014 The module SHALL have the port flags_we, output, 6 bits: per-flag write enable, same bit order as flags.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE; ready=1 only in IDLE.
REQ-016 In IDLE with start=1, the module SHALL latch op, size, operand, cy_in and n=count[4:0], then go to SHIFT if n>0, else to DONE.
REQ-017 A start input while not in IDLE SHALL be ignored, with no queuing.
REQ-018 In SHIFT, the module SHALL perform exactly one 1-bit step per cycle and decrement n; after the step taking n to 0 it SHALL go to DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1 and result, flags, flags_we valid, then return to IDLE.
REQ-020 Latency SHALL be start-accept edge to done high = n+1 cycles (n=0 gives 1 cycle).
REQ-021 In byte mode, steps SHALL act on bits 7:0 only, with bits 15:8 passing through unchanged; in word mode, steps SHALL act on bits 15:0; msb SHALL be 7 or 15 accordingly.
REQ-022 Each step SHALL follow these rules:
- ROL: CY<=msb, insert old msb at bit 0.
- ROR: CY<=bit0, insert bit0 at msb.
- ROLC: insert CY at bit 0, CY<=msb.
- RORC: insert CY at msb, CY<=bit0.
- SHL: CY<=msb, insert 0.
- SHR: CY<=bit0, insert 0 at msb.
- SHRA: CY<=bit0, msb replicated.
REQ-023 Internal CY SHALL start from cy_in for every op.
REQ-024 Final V SHALL be computed as follows:
- ROL/ROLC/SHL: result[msb] XOR CY.
- ROR/RORC: result[msb] XOR result[msb-1].
- SHR: original operand[msb].
- SHRA: 0.
REQ-025 For SHL/SHR/SHRA, the module SHALL output S=result[msb], Z=(sized result==0), and P=1 when result[7:0] has even ones count.
REQ-026 flags_we SHALL be 0b111110 for shifts and 0b000110 for rotates, with AC never written.
REQ-027 When n=0, DONE SHALL present result=operand and flags_we=0.
REQ-028 result, flags and flags_we SHALL hold their DONE values until the next start is accepted.
REQ-029 The count SHALL be masked to 5 bits: word counts of 16-31 are real 16-31 steps, and byte rotates are not reduced modulo 8.

Reset
REQ-030 While reset_n=0, asynchronously: state SHALL be IDLE, ready=1, done=0, result=0, flags=0, flags_we=0.
REQ-031 Reset asserted during SHIFT or DONE SHALL abort the operation, with no done pulse produced.
REQ-032 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-033 ROL, size=0, operand=0x0081, count=1 -> done 2 cycles after accept; result=0x0003, CY=1, V=1, flags_we=0x06.
REQ-034 RORC, size=1, operand=0x0001, count=1, cy_in=0 -> result=0x0000, CY=1, V=0.
REQ-035 SHL, size=1, operand=0x8001, count=17 -> done at cycle 18; result=0x0000, CY=0, Z=1, P=1, S=0, V=0.
REQ-036 Any op, count=0x20, operand=0x1234 -> done after 1 cycle; result=0x1234, flags_we=0; start while busy is ignored.
REQ-037 SHRA, size=0, operand=0xAB80, count=3 -> result=0xABF0, CY=0, S=1, Z=0, P=1, V=0.
REQ-038 reset_n pulsed low during cycle 5 of an 18-cycle SHL -> ready=1 and result=0 immediately, with no done pulse; the next start completes normally.
